// File: rtl/vram_arbiter_n.sv
// N-port time-slotted VRAM arbiter in front of main_ram_generic.
// Each port owns one slot per round; idle slots may optionally be lent round-robin.
module vram_arbiter_n #(
   parameter int          NUM_PORTS       = 4,
   parameter int          ADDR_WIDTH      = 15,
   parameter int          DATA_WIDTH      = 32,
   parameter int          WORK_CONSERVING = 1,
   parameter logic [7:0]  WRITE_PORT_MASK = 8'b0000_0001,
   localparam int         BSEL_WIDTH      = DATA_WIDTH / 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wrdata,
   input  logic [NUM_PORTS*BSEL_WIDTH-1:0]  port_wrbytesel,
   input  logic [NUM_PORTS-1:0]             port_strobe,
   input  logic [NUM_PORTS-1:0]             port_write,
   output logic [NUM_PORTS-1:0]             port_ack,
   output logic [NUM_PORTS-1:0]             port_wrerr,
   output logic [DATA_WIDTH-1:0]            rddata,
   output logic [ADDR_WIDTH-1:0]            ram_addr,
   output logic [DATA_WIDTH-1:0]            ram_wrdata,
   output logic [BSEL_WIDTH-1:0]            ram_wrbytesel,
   output logic                             ram_write,
   input  logic [DATA_WIDTH-1:0]            ram_rddata
);

   localparam int                    SLOT_W    = $clog2(NUM_PORTS);
   localparam logic [NUM_PORTS-1:0]  WR_MASK   = WRITE_PORT_MASK[NUM_PORTS-1:0];
   localparam logic [SLOT_W-1:0]     LAST_SLOT = SLOT_W'(NUM_PORTS - 1);

   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [NUM_PORTS-1:0]  portAck_q, portAck_d;
   logic [NUM_PORTS-1:0]  portWrerr_q, portWrerr_d;

   logic [NUM_PORTS-1:0]  eligible;
   logic                  grantValid;
   logic [SLOT_W-1:0]     grantIdx;
   logic [SLOT_W:0]       candSum;

   // A port is blocked in its own ack cycle so a held strobe is not served twice.
   assign eligible = port_strobe & ~portAck_q;

   assign slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);

   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      candSum    = '0;
      if (eligible[slot_q]) begin
         grantValid = 1'b1;
         grantIdx   = slot_q;
      end else if (WORK_CONSERVING != 0) begin
         for (int k = 1; k < NUM_PORTS; k++) begin
            candSum = {1'b0, slot_q} + (SLOT_W+1)'(k);
            if (candSum >= (SLOT_W+1)'(NUM_PORTS)) begin
               candSum = candSum - (SLOT_W+1)'(NUM_PORTS);
            end
            if (!grantValid && eligible[candSum[SLOT_W-1:0]]) begin
               grantValid = 1'b1;
               grantIdx   = candSum[SLOT_W-1:0];
            end
         end
      end
   end

   always_comb begin
      ram_addr      = '0;
      ram_wrdata    = '0;
      ram_wrbytesel = '0;
      ram_write     = 1'b0;
      portAck_d     = '0;
      portWrerr_d   = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grantValid && (grantIdx == SLOT_W'(p))) begin
            ram_addr       = port_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wrdata     = port_wrdata[p*DATA_WIDTH +: DATA_WIDTH];
            ram_wrbytesel  = port_wrbytesel[p*BSEL_WIDTH +: BSEL_WIDTH];
            // Writes from read-only ports degrade to reads and are flagged.
            ram_write      = port_write[p] & WR_MASK[p] & ~rst;
            portAck_d[p]   = 1'b1;
            portWrerr_d[p] = port_write[p] & ~WR_MASK[p];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q      <= '0;
         portAck_q   <= '0;
         portWrerr_q <= '0;
      end else begin
         slot_q      <= slot_d;
         portAck_q   <= portAck_d;
         portWrerr_q <= portWrerr_d;
      end
   end

   assign port_ack   = portAck_q;
   assign port_wrerr = portWrerr_q;
   assign rddata     = ram_rddata;

endmodule

// File: tb/tb_vram_arbiter_n.sv
// Directed bench for vram_arbiter_n: a 4-port strict instance with a RAM model,
// plus strict and work-conserving 3-port instances sharing one stimulus.
module tb_vram_arbiter_n;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;

   logic [59:0]   portAddrA;
   logic [127:0]  portWrdataA;
   logic [15:0]   portBselA;
   logic [3:0]    strobeA, writeA, ackA, wrerrA;
   logic [31:0]   rddataA, ramWrdataA, ramRdA;
   logic [14:0]   ramAddrA;
   logic [3:0]    ramBselA;
   logic          ramWriteA;
   logic [31:0]   mem [0:255];

   logic [44:0]   addrBC;
   logic [95:0]   wrdataBC;
   logic [11:0]   bselBC;
   logic [2:0]    strobeBC, writeBC;
   logic [31:0]   ramRdBC;
   logic [2:0]    ackB, wrerrB, ackC, wrerrC;
   logic [31:0]   rddataB, rddataC, ramWrdataB, ramWrdataC;
   logic [14:0]   ramAddrB, ramAddrC;
   logic [3:0]    ramBselB, ramBselC;
   logic          ramWriteB, ramWriteC;

   vram_arbiter_n #(.NUM_PORTS(4), .ADDR_WIDTH(15), .DATA_WIDTH(32),
                    .WORK_CONSERVING(0), .WRITE_PORT_MASK(8'b0000_0001)) dutA (
      .clk(clk), .rst(rst), .port_addr(portAddrA), .port_wrdata(portWrdataA),
      .port_wrbytesel(portBselA), .port_strobe(strobeA), .port_write(writeA),
      .port_ack(ackA), .port_wrerr(wrerrA), .rddata(rddataA), .ram_addr(ramAddrA),
      .ram_wrdata(ramWrdataA), .ram_wrbytesel(ramBselA), .ram_write(ramWriteA),
      .ram_rddata(ramRdA));

   vram_arbiter_n #(.NUM_PORTS(3), .ADDR_WIDTH(15), .DATA_WIDTH(32),
                    .WORK_CONSERVING(0), .WRITE_PORT_MASK(8'b0000_0001)) dutB (
      .clk(clk), .rst(rst), .port_addr(addrBC), .port_wrdata(wrdataBC),
      .port_wrbytesel(bselBC), .port_strobe(strobeBC), .port_write(writeBC),
      .port_ack(ackB), .port_wrerr(wrerrB), .rddata(rddataB), .ram_addr(ramAddrB),
      .ram_wrdata(ramWrdataB), .ram_wrbytesel(ramBselB), .ram_write(ramWriteB),
      .ram_rddata(ramRdBC));

   vram_arbiter_n #(.NUM_PORTS(3), .ADDR_WIDTH(15), .DATA_WIDTH(32),
                    .WORK_CONSERVING(1), .WRITE_PORT_MASK(8'b0000_0001)) dutC (
      .clk(clk), .rst(rst), .port_addr(addrBC), .port_wrdata(wrdataBC),
      .port_wrbytesel(bselBC), .port_strobe(strobeBC), .port_write(writeBC),
      .port_ack(ackC), .port_wrerr(wrerrC), .rddata(rddataC), .ram_addr(ramAddrC),
      .ram_wrdata(ramWrdataC), .ram_wrbytesel(ramBselC), .ram_write(ramWriteC),
      .ram_rddata(ramRdBC));

   function automatic logic [31:0] preload(input int a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   // Byte-enabled RAM with one cycle of read latency; reset reloads the known pattern.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= preload(i);
      end else if (ramWriteA) begin
         for (int b = 0; b < 4; b++)
            if (ramBselA[b]) mem[ramAddrA[7:0]][b*8 +: 8] <= ramWrdataA[b*8 +: 8];
      end
      ramRdA <= mem[ramAddrA[7:0]];
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic applyStimulus(input int p, input logic wr, input logic [14:0] addr,
                                input logic [31:0] data, input logic [3:0] bsel);
      portAddrA[p*15 +: 15]  = addr;
      portWrdataA[p*32 +: 32] = data;
      portBselA[p*4 +: 4]    = bsel;
      writeA[p]              = wr;
      strobeA[p]             = 1'b1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cyc %0d: observed %h expected %h", tag, cyc, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic grantB, grantC, ackExpB, ackExpC;
      rst         = 1'b1;
      portAddrA   = '0;
      portWrdataA = '0;
      portBselA   = '0;
      strobeA     = '0;
      writeA      = '0;
      addrBC      = {15'h55, 30'h0};
      wrdataBC    = {32'h0000_1234, 64'h0};
      bselBC      = {4'hF, 8'h0};
      strobeBC    = '0;
      writeBC     = '0;
      ramRdBC     = 32'h600D_F00D;

      step();
      step();
      checkOutput("rstAck", 64'(ackA), 64'h0);
      checkOutput("rstWrerr", 64'(wrerrA), 64'h0);
      checkOutput("rstRamWrite", 64'(ramWriteA), 64'h0);

      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("idleWrite", 64'(ramWriteA), 64'h0);
         checkOutput("idleAddr", 64'(ramAddrA), 64'h0);
         checkOutput("idleAck", 64'(ackA), 64'h0);
         step();
      end

      // Strict round robin: start all four reads at slot 0.
      while (cyc % 4 != 0) step();
      for (int p = 0; p < 4; p++) applyStimulus(p, 1'b0, 15'(32 + p), 32'h0, 4'h0);
      step();
      for (int i = 0; i < 4; i++) begin
         checkOutput("rrAck", 64'(ackA), 64'(4'b0001 << i));
         checkOutput("rrData", 64'(rddataA), 64'(preload(32 + i)));
         strobeA[i] = 1'b0;
         step();
      end

      // Partial write from p0, read back by p1.
      applyStimulus(0, 1'b1, 15'h10, 32'hDEAD_BEEF, 4'b0101);
      while (cyc < 16) begin
         checkOutput("wrWaitAck", 64'(ackA), 64'h0);
         step();
      end
      checkOutput("wrRamWrite", 64'(ramWriteA), 64'h1);
      checkOutput("wrRamAddr", 64'(ramAddrA), 64'h10);
      checkOutput("wrRamData", 64'(ramWrdataA), 64'hDEAD_BEEF);
      checkOutput("wrRamBsel", 64'(ramBselA), 64'h5);
      applyStimulus(1, 1'b0, 15'h10, 32'h0, 4'h0);
      step();
      checkOutput("wrAck", 64'(ackA), 64'h1);
      checkOutput("wrWrerr", 64'(wrerrA), 64'h0);
      strobeA[0] = 1'b0;
      #1;
      checkOutput("rdRamWrite", 64'(ramWriteA), 64'h0);
      checkOutput("rdRamAddr", 64'(ramAddrA), 64'h10);
      step();
      checkOutput("rdAck", 64'(ackA), 64'h2);
      checkOutput("rdMerged", 64'(rddataA), 64'hC0AD_00EF);
      strobeA[1] = 1'b0;

      // Write attempt from read-only p2 (slot 2 now).
      applyStimulus(2, 1'b1, 15'h30, 32'h0000_1234, 4'hF);
      #1;
      checkOutput("roRamWrite", 64'(ramWriteA), 64'h0);
      checkOutput("roRamAddr", 64'(ramAddrA), 64'h30);
      step();
      checkOutput("roAck", 64'(ackA), 64'h4);
      checkOutput("roWrerr", 64'(wrerrA), 64'h4);
      strobeA[2] = 1'b0;

      // Reset lands in a p0 write grant cycle.
      applyStimulus(0, 1'b1, 15'h40, 32'hFFFF_FFFF, 4'hF);
      step();
      checkOutput("preRstWrite", 64'(ramWriteA), 64'h1);
      rst = 1'b1;
      #1;
      checkOutput("rstGrantWrite", 64'(ramWriteA), 64'h0);
      step();
      checkOutput("rstGrantAck", 64'(ackA), 64'h0);
      rst = 1'b0;
      cyc = 0;
      #1;
      checkOutput("postRstSlot0", 64'(ramWriteA), 64'h1);
      checkOutput("postRstAddr", 64'(ramAddrA), 64'h40);
      step();
      checkOutput("postRstAck", 64'(ackA), 64'h1);
      strobeA[0] = 1'b0;

      // Three ports, only p2 strobing continuously, from slot 0.
      step();
      step();
      strobeBC = 3'b100;
      #1;
      while (cyc <= 15) begin
         grantB  = (cyc >= 5) && (cyc % 3 == 2);
         ackExpB = (cyc >= 6) && (cyc % 3 == 0);
         grantC  = (cyc >= 3) && (cyc % 2 == 1);
         ackExpC = (cyc >= 4) && (cyc % 2 == 0);
         checkOutput("strictBus", {12'h0, ramWriteB, ramBselB, ramAddrB, ramWrdataB},
                     grantB ? {12'h0, 1'b0, 4'hF, 15'h55, 32'h0000_1234} : 64'h0);
         checkOutput("strictAck", 64'({wrerrB, ackB}), 64'({3'b000, ackExpB ? 3'b100 : 3'b000}));
         checkOutput("wcBus", {12'h0, ramWriteC, ramBselC, ramAddrC, ramWrdataC},
                     grantC ? {12'h0, 1'b0, 4'hF, 15'h55, 32'h0000_1234} : 64'h0);
         checkOutput("wcAck", 64'({wrerrC, ackC}), 64'({3'b000, ackExpC ? 3'b100 : 3'b000}));
         step();
      end
      checkOutput("strictRdData", 64'(rddataB), 64'h600D_F00D);
      checkOutput("wcRdData", 64'(rddataC), 64'h600D_F00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
